// File: rtl/mfm_pkg.sv
// rtl/mfm_pkg.sv - shared symbol codes, FSM states and pattern helper for the MFM sync path
package mfm_pkg;

    localparam logic [1:0] SYM_NONE = 2'b00;
    localparam logic [1:0] SYM_S    = 2'b01;
    localparam logic [1:0] SYM_M    = 2'b10;
    localparam logic [1:0] SYM_L    = 2'b11;

    // Widest packed pattern the helper accepts (16 symbols).
    localparam int PAT_W_MAX = 32;

    typedef enum logic [1:0] {
        IDLE,
        HUNT,
        LOCKED
    } mfm_state_t;

    function automatic logic [1:0] pat_elem(input logic [PAT_W_MAX-1:0] pat, input logic [3:0] k);
        logic [PAT_W_MAX-1:0] sh;
        sh = pat >> {k, 1'b0};
        return sh[1:0];
    endfunction

endpackage

// File: rtl/mfm_sym_decode.sv
// rtl/mfm_sym_decode.sv - one-hot S/M/L/Error strobes to symbol code with valid/error flags
module mfm_sym_decode
    import mfm_pkg::*;
(
    input  logic       s,
    input  logic       m,
    input  logic       l,
    input  logic       err,
    output logic [1:0] sym,
    output logic       sym_valid,
    output logic       sym_error
);

    logic [1:0] n_hot;

    always_comb begin
        n_hot     = {1'b0, s} + {1'b0, m} + {1'b0, l};
        // Colliding strobes mean the classifier lost track; treat like an explicit error.
        sym_error = err || (n_hot > 2'd1);
        sym_valid = !sym_error && (n_hot == 2'd1);
        sym       = SYM_NONE;
        if (l)
            sym = SYM_L;
        else if (m)
            sym = SYM_M;
        else if (s)
            sym = SYM_S;
    end

endmodule

// File: rtl/mfm_sync_prog.sv
// rtl/mfm_sync_prog.sv - programmable MFM sync-mark detector with repeat count and lock window
module mfm_sync_prog
    import mfm_pkg::*;
#(
    parameter int MAX_LEN = 8,
    parameter int REP_W   = 2,
    parameter int CNT_W   = 16
) (
    input  logic                         i_Clk,
    input  logic                         i_Reset,
    input  logic                         i_Enable,
    input  logic                         i_S,
    input  logic                         i_M,
    input  logic                         i_L,
    input  logic                         i_Error,
    input  logic [2*MAX_LEN-1:0]         i_Pattern,
    input  logic [$clog2(MAX_LEN+1)-1:0] i_PatLen,
    input  logic [REP_W-1:0]             i_Repeat,
    input  logic [CNT_W-1:0]             i_LockLen,
    output logic                         o_Sync,
    output logic                         o_Locked,
    output logic                         o_LockLost,
    output logic [CNT_W-1:0]             o_SymCnt,
    output logic [$clog2(MAX_LEN+1)-1:0] o_MatchIdx
);

    localparam int IW = $clog2(MAX_LEN+1);

    mfm_state_t             state_q, state_d;
    logic [2*MAX_LEN-1:0]   pat_q, pat_d;
    logic [IW-1:0]          len_q, len_d;
    logic [REP_W-1:0]       rep_req_q, rep_req_d;
    logic [CNT_W-1:0]       lock_len_q, lock_len_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [REP_W-1:0]       rep_q, rep_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   sync_q, sync_d;
    logic                   lost_q, lost_d;

    logic [1:0]             sym;
    logic                   sym_valid;
    logic                   sym_error;

    mfm_sym_decode u_decode (
        .s         (i_S),
        .m         (i_M),
        .l         (i_L),
        .err       (i_Error),
        .sym       (sym),
        .sym_valid (sym_valid),
        .sym_error (sym_error)
    );

    logic [PAT_W_MAX-1:0]   pat_ext;
    logic [1:0]             cur_elem;
    logic [1:0]             first_elem;
    logic                   len_ok;
    logic                   is_last;
    logic [REP_W:0]         rep_inc;
    logic [CNT_W-1:0]       cnt_inc;

    always_comb begin
        pat_ext    = PAT_W_MAX'(pat_q);
        cur_elem   = pat_elem(pat_ext, 4'(idx_q));
        first_elem = pat_elem(pat_ext, 4'd0);
        len_ok     = (len_q != '0) && (len_q <= IW'(MAX_LEN));
        is_last    = (idx_q == len_q - IW'(1));
        rep_inc    = {1'b0, rep_q} + (REP_W+1)'(1);
        cnt_inc    = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
    end

    always_comb begin
        state_d    = state_q;
        pat_d      = pat_q;
        len_d      = len_q;
        rep_req_d  = rep_req_q;
        lock_len_d = lock_len_q;
        idx_d      = idx_q;
        rep_d      = rep_q;
        cnt_d      = cnt_q;
        sync_d     = 1'b0;
        lost_d     = 1'b0;

        if (!i_Enable) begin
            state_d = IDLE;
            idx_d   = '0;
            rep_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    pat_d      = i_Pattern;
                    len_d      = i_PatLen;
                    rep_req_d  = (i_Repeat == '0) ? REP_W'(1) : i_Repeat;
                    lock_len_d = i_LockLen;
                    idx_d      = '0;
                    rep_d      = '0;
                    state_d    = HUNT;
                end
                HUNT: begin
                    if (sym_error) begin
                        idx_d = '0;
                        rep_d = '0;
                    end else if (sym_valid && len_ok) begin
                        if (sym == cur_elem) begin
                            if (!is_last) begin
                                idx_d = idx_q + IW'(1);
                            end else if (rep_inc == {1'b0, rep_req_q}) begin
                                sync_d  = 1'b1;
                                cnt_d   = '0;
                                state_d = LOCKED;
                                idx_d   = '0;
                                rep_d   = '0;
                            end else begin
                                rep_d = rep_inc[REP_W-1:0];
                                idx_d = '0;
                            end
                        end else begin
                            // Single-step realign: the failing symbol may start a new attempt.
                            rep_d = '0;
                            idx_d = (sym == first_elem) ? IW'(1) : '0;
                        end
                    end
                end
                LOCKED: begin
                    if (sym_error) begin
                        lost_d  = 1'b1;
                        state_d = HUNT;
                    end else if (sym_valid) begin
                        cnt_d = cnt_inc;
                        if ((lock_len_q != '0) && (cnt_inc == lock_len_q))
                            state_d = HUNT;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state_q    <= IDLE;
            pat_q      <= '0;
            len_q      <= '0;
            rep_req_q  <= '0;
            lock_len_q <= '0;
            idx_q      <= '0;
            rep_q      <= '0;
            cnt_q      <= '0;
            sync_q     <= 1'b0;
            lost_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pat_q      <= pat_d;
            len_q      <= len_d;
            rep_req_q  <= rep_req_d;
            lock_len_q <= lock_len_d;
            idx_q      <= idx_d;
            rep_q      <= rep_d;
            cnt_q      <= cnt_d;
            sync_q     <= sync_d;
            lost_q     <= lost_d;
        end
    end

    assign o_Sync     = sync_q;
    assign o_Locked   = (state_q == LOCKED);
    assign o_LockLost = lost_q;
    assign o_SymCnt   = cnt_q;
    assign o_MatchIdx = idx_q;

endmodule

// File: tb/tb_mfm_sync_prog.sv
// tb/tb_mfm_sync_prog.sv - self-checking bench for mfm_sync_prog
module tb_mfm_sync_prog;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1, en = 1'b0, s_i = 1'b0, m_i = 1'b0, l_i = 1'b0, err_i = 1'b0;
    logic [15:0] pat = '0;
    logic [3:0]  plen = '0;
    logic [1:0]  rep = '0;
    logic [15:0] llen = '0;

    logic        sync, locked, lost;
    logic [15:0] symcnt;
    logic [3:0]  midx;

    int total = 0;
    int bad = 0;

    mfm_sync_prog #(.MAX_LEN(8), .REP_W(2), .CNT_W(16)) dut (
        .i_Clk      (clk),
        .i_Reset    (rst),
        .i_Enable   (en),
        .i_S        (s_i),
        .i_M        (m_i),
        .i_L        (l_i),
        .i_Error    (err_i),
        .i_Pattern  (pat),
        .i_PatLen   (plen),
        .i_Repeat   (rep),
        .i_LockLen  (llen),
        .o_Sync     (sync),
        .o_Locked   (locked),
        .o_LockLost (lost),
        .o_SymCnt   (symcnt),
        .o_MatchIdx (midx)
    );

    // Behavioural reference: 0=idle 1=hunt 2=locked; symbols 1=S 2=M 3=L.
    int st = 0, mi = 0, mr = 0, mc = 0, mlen = 0, mrep = 1, mlock = 0;
    int mpat[8];
    int ms = 0, mlost = 0;

    task automatic model_step();
        int nstr, sym;
        bit badsym, good;
        nstr   = int'(s_i) + int'(m_i) + int'(l_i);
        badsym = err_i || nstr > 1;
        good   = !badsym && nstr == 1;
        sym    = l_i ? 3 : (m_i ? 2 : 1);
        ms = 0; mlost = 0;
        if (rst) begin
            st = 0; mi = 0; mr = 0; mc = 0; mlen = 0; mrep = 1; mlock = 0;
            for (int k = 0; k < 8; k++) mpat[k] = 0;
        end else if (!en) begin
            st = 0; mi = 0; mr = 0; mc = 0;
        end else if (st == 0) begin
            for (int k = 0; k < 8; k++) mpat[k] = int'(pat[2*k +: 2]);
            mlen  = int'(plen);
            mrep  = (rep == 0) ? 1 : int'(rep);
            mlock = int'(llen);
            mi = 0; mr = 0; st = 1;
        end else if (st == 1) begin
            if (badsym) begin
                mi = 0; mr = 0;
            end else if (good && mlen >= 1 && mlen <= 8) begin
                if (sym == mpat[mi]) begin
                    if (mi < mlen - 1) mi++;
                    else if (mr + 1 == mrep) begin
                        ms = 1; mc = 0; st = 2; mi = 0; mr = 0;
                    end else begin
                        mr++; mi = 0;
                    end
                end else begin
                    mr = 0;
                    mi = (sym == mpat[0]) ? 1 : 0;
                end
            end
        end else begin
            if (badsym) begin
                mlost = 1; st = 1;
            end else if (good) begin
                if (mc < 65535) mc++;
                if (mlock != 0 && mc == mlock) st = 1;
            end
        end
    endtask

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step_raw(input logic r, input logic e, input logic a_s, input logic a_m,
                            input logic a_l, input logic a_e);
        rst = r; en = e; s_i = a_s; m_i = a_m; l_i = a_l; err_i = a_e;
        @(posedge clk);
        model_step();
        #1;
        check("model_sync", sync, ms);
        check("model_locked", locked, (st == 2) ? 1 : 0);
        check("model_lockloss", lost, mlost);
        check("model_symcnt", symcnt, mc);
        check("model_idx", midx, mi);
    endtask

    task automatic step(input logic r, input logic e, input int sym, input logic a_e);
        step_raw(r, e, sym == 1, sym == 2, sym == 3, a_e);
    endtask

    task automatic feed_lmlm();
        step(0, 1, 3, 0); step(0, 1, 2, 0); step(0, 1, 3, 0); step(0, 1, 2, 0);
    endtask

    task automatic do_reset();
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
    endtask

    typedef struct {
        logic en;
        int   sym;
        logic err;
        int   e_sync;
        int   e_locked;
        int   e_lost;
        int   e_cnt;
        int   e_idx;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input logic e, input int sy, input logic er, input int es,
                                input int el, input int elo, input int ec, input int ei);
        vec_t v;
        v.en = e; v.sym = sy; v.err = er; v.e_sync = es; v.e_locked = el;
        v.e_lost = elo; v.e_cnt = ec; v.e_idx = ei;
        return v;
    endfunction

    initial begin
        // LMLM, repeat 1, no lock window
        vq.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));
        vq.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0));
        vq.push_back(mk(1, 3, 0, 0, 0, 0, 0, 1));
        vq.push_back(mk(1, 2, 0, 0, 0, 0, 0, 2));
        vq.push_back(mk(1, 3, 0, 0, 0, 0, 0, 3));
        vq.push_back(mk(1, 2, 0, 1, 1, 0, 0, 0));
        vq.push_back(mk(1, 1, 0, 0, 1, 0, 1, 0));
        vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
        vq.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));
        vq.push_back(mk(1, 3, 0, 0, 0, 0, 0, 1));
        vq.push_back(mk(1, 3, 0, 0, 0, 0, 0, 1));
        vq.push_back(mk(1, 2, 0, 0, 0, 0, 0, 2));
        vq.push_back(mk(1, 3, 0, 0, 0, 0, 0, 3));
        vq.push_back(mk(1, 2, 0, 1, 1, 0, 0, 0));
        vq.push_back(mk(1, 2, 1, 0, 0, 1, 0, 0));
        vq.push_back(mk(1, 3, 0, 0, 0, 0, 0, 1));
        vq.push_back(mk(1, 2, 0, 0, 0, 0, 0, 2));
        vq.push_back(mk(1, 3, 0, 0, 0, 0, 0, 3));
        vq.push_back(mk(1, 2, 0, 1, 1, 0, 0, 0));
        vq.push_back(mk(1, 0, 0, 0, 1, 0, 0, 0));
        vq.push_back(mk(1, 0, 1, 0, 0, 1, 0, 0));

        pat = 16'h00BB; plen = 4'd4; rep = 2'd1; llen = 16'd0;
        do_reset();
        check("reset_sync", sync, 0);
        check("reset_locked", locked, 0);
        check("reset_lockloss", lost, 0);
        check("reset_symcnt", symcnt, 0);
        check("reset_idx", midx, 0);

        foreach (vq[i]) begin
            step(0, vq[i].en, vq[i].sym, vq[i].err);
            check($sformatf("vec%0d_sync", i), sync, vq[i].e_sync);
            check($sformatf("vec%0d_locked", i), locked, vq[i].e_locked);
            check($sformatf("vec%0d_lockloss", i), lost, vq[i].e_lost);
            check($sformatf("vec%0d_symcnt", i), symcnt, vq[i].e_cnt);
            check($sformatf("vec%0d_idx", i), midx, vq[i].e_idx);
        end

        // Repeat 3: an intervening S clears the repeat count.
        pat = 16'h00BB; plen = 4'd4; rep = 2'd3; llen = 16'd0;
        do_reset();
        step(0, 1, 0, 0);
        feed_lmlm(); feed_lmlm();
        check("rep3_no_sync_after_2", sync, 0);
        step(0, 1, 1, 0);
        feed_lmlm(); feed_lmlm();
        check("rep3_no_sync_after_4", sync, 0);
        feed_lmlm();
        check("rep3_sync_on_5th", sync, 1);
        check("rep3_locked", locked, 1);

        // Lock window of 4 symbols, then a second sync.
        pat = 16'h00BB; plen = 4'd4; rep = 2'd0; llen = 16'd4;
        do_reset();
        step(0, 1, 0, 0);
        feed_lmlm();
        check("win_sync", sync, 1);
        step(0, 1, 1, 0); step(0, 1, 1, 0); step(0, 1, 1, 0);
        check("win_cnt3_locked", locked, 1);
        check("win_cnt3", symcnt, 3);
        step(0, 1, 1, 0);
        check("win_cnt4", symcnt, 4);
        check("win_unlocked", locked, 0);
        feed_lmlm();
        check("win_resync", sync, 1);
        check("win_resync_cnt", symcnt, 0);

        // Colliding strobes drop the partial match; invalid lengths never sync.
        pat = 16'h00BB; plen = 4'd4; rep = 2'd1; llen = 16'd0;
        do_reset();
        step(0, 1, 0, 0);
        step(0, 1, 3, 0); step(0, 1, 2, 0);
        check("multi_pre_idx", midx, 2);
        step_raw(0, 1, 1, 1, 0, 0);
        check("multi_idx_cleared", midx, 0);
        plen = 4'd0;
        step(0, 0, 0, 0); step(0, 1, 0, 0);
        feed_lmlm();
        check("len0_no_sync", sync, 0);
        check("len0_idx", midx, 0);
        plen = 4'd9;
        step(0, 0, 0, 0); step(0, 1, 0, 0);
        feed_lmlm();
        check("len9_no_sync", sync, 0);
        pat = 16'h0001; plen = 4'd1; rep = 2'd2;
        step(0, 0, 0, 0); step(0, 1, 0, 0);
        step(0, 1, 1, 0);
        check("len1_rep2_first", sync, 0);
        step(0, 1, 1, 0);
        check("len1_rep2_second", sync, 1);

        // Reset mid-pattern with new config presented while reset is high.
        pat = 16'h00BB; plen = 4'd4; rep = 2'd1; llen = 16'd0;
        do_reset();
        step(0, 1, 0, 0);
        step(0, 1, 3, 0); step(0, 1, 2, 0);
        check("rst_pre_idx", midx, 2);
        pat = 16'h0005; plen = 4'd2;
        step(1, 1, 3, 0);
        check("rst_sync", sync, 0);
        check("rst_locked", locked, 0);
        check("rst_idx", midx, 0);
        step(0, 1, 0, 0);
        step(0, 1, 1, 0);
        check("rst_newcfg_idx", midx, 1);
        step(0, 1, 1, 0);
        check("rst_newcfg_sync", sync, 1);

        // Randomized traffic against the reference model.
        for (int round = 0; round < 6; round++) begin
            pat  = 16'($urandom);
            plen = 4'($urandom_range(1, 4));
            rep  = 2'($urandom_range(0, 3));
            llen = 16'($urandom_range(0, 8));
            do_reset();
            for (int c = 0; c < 600; c++) begin
                int r, sy;
                if ($urandom_range(0, 49) == 0) begin
                    pat  = 16'($urandom);
                    plen = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15))
                                                       : 4'($urandom_range(1, 4));
                    rep  = 2'($urandom_range(0, 3));
                    llen = 16'($urandom_range(0, 8));
                end
                r = int'($urandom_range(0, 199));
                if (r == 0) begin
                    step(1, 1, 0, 0);
                end else if (r < 3) begin
                    step(0, 0, 0, 0);
                end else if (r < 8) begin
                    step(0, 1, int'($urandom_range(0, 3)), 1);
                end else if (r < 11) begin
                    step_raw(0, 1, 1'b1, 1'($urandom), 1'b1, 0);
                end else if (r < 50) begin
                    step(0, 1, 0, 0);
                end else begin
                    sy = int'($urandom_range(1, 3));
                    if ($urandom_range(0, 1) == 1 && st == 1 && mlen >= 1 && mlen <= 8
                        && mpat[mi] != 0)
                        sy = mpat[mi];
                    step(0, 1, sy, 0);
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mfm_sync_prog.md
Name: mfm_sync_prog

Overview:
Programmable sync-mark detector for the MFM symbol stream. It sits after the pulse-interval classifier, which emits S/M/L/Error strobes, and before the header/data byte deframer.
- Matches a runtime-configurable symbol pattern of up to MAX_LEN symbols, with a required consecutive repeat count. This covers both the LMLM header mark and repeated A1-style marks.
- Realigns on partial mismatch, so overlapping prefixes such as L-L-M-L-M are still caught.
- After a match, holds a lock window and counts symbols for the deframer.

Parameters:
MAX_LEN, 8, maximum pattern length in symbols
REP_W, 2, width of the repeat-count configuration
CNT_W, 16, width of the lock-window and symbol counters

Ports:
i_Clk  in  1  clock
i_Reset  in  1  synchronous, active-high reset
i_Enable  in  1  detector enable; low forces IDLE
i_S  in  1  short-interval symbol strobe
i_M  in  1  medium-interval symbol strobe
i_L  in  1  long-interval symbol strobe
i_Error  in  1  classifier error strobe
i_Pattern  in  2*MAX_LEN  pattern; element k is at bits [2k+1:2k]; element 0 is matched first
i_PatLen  in  $clog2(MAX_LEN+1)  pattern length in symbols
i_Repeat  in  REP_W  consecutive full matches required (0 is treated as 1)
i_LockLen  in  CNT_W  symbols to remain locked after sync (0 means stay locked until error or disable)
o_Sync  out  1  one-cycle pulse on completed sync
o_Locked  out  1  high while in LOCKED
o_LockLost  out  1  one-cycle pulse when lock ends on i_Error
o_SymCnt  out  CNT_W  valid symbols received since sync
o_MatchIdx  out  $clog2(MAX_LEN+1)  current partial-match index (debug)

Behaviour:
- Clock and reset
  - i_Reset is sampled on the rising edge of i_Clk only.
  - Reset state: IDLE. All outputs are 0, and the internal config registers are cleared.
- Symbol decode
  - Exactly one of S/M/L high with i_Error low gives a valid symbol: S=2'b01, M=2'b10, L=2'b11.
  - More than one of S/M/L high in the same cycle is treated as an error.
  - All strobes low: no event; state holds.
- States: IDLE, HUNT, LOCKED.
- IDLE
  - On i_Enable=1: latch i_Pattern, i_PatLen, i_Repeat (0 becomes 1) and i_LockLen into internal registers, clear idx and rep, then go to HUNT.
  - Config inputs are ignored at all other times.
- HUNT, on a valid symbol sym
  - sym == pat[idx] and idx < len-1: idx <= idx+1.
  - sym == pat[idx] and idx == len-1 (full match):
    - If rep+1 == repeat: o_Sync=1 for one cycle, o_SymCnt <= 0, go to LOCKED, idx <= 0, rep <= 0.
    - Otherwise: rep <= rep+1, idx <= 0.
  - Mismatch: rep <= 0, and idx <= (sym == pat[0]) ? 1 : 0. A single-step realign is the full requirement; no KMP.
  - Error: idx <= 0, rep <= 0.
  - PatLen == 0 or PatLen > MAX_LEN: never match; stay in HUNT.
- LOCKED
  - o_Locked=1.
  - On each valid symbol: o_SymCnt <= o_SymCnt+1, saturating at all-ones.
  - If LockLen != 0 and the incremented count equals LockLen: go to HUNT, o_Locked <= 0.
  - On error: o_LockLost=1 for one cycle, go to HUNT, o_SymCnt holds its last value.
  - Pattern matching is suspended while locked.
- Latency
  - o_Sync, o_Locked and o_LockLost are registered.
  - They assert in the cycle after the clock edge that samples the terminating strobe.
- i_Enable low in any state: go to IDLE on the next edge. o_Locked, o_Sync and o_LockLost clear; o_SymCnt clears.
- Reset mid-operation: returns to IDLE on the same edge and overrides every other event.
- Simultaneous i_Error with any S/M/L strobe: error wins.

Decomposition:
- Package mfm_pkg:
  - symbol code constants SYM_NONE/S/M/L
  - state enum IDLE/HUNT/LOCKED
  - a function returning pattern element k
- Sub-module mfm_sym_decode: combinational decode of the one-hot strobes to a 2-bit code plus valid and error flags. It is shared with the deframer.

Test Plan:
- Pattern LMLM, len 4, repeat 1; feed S L M L M S → o_Sync pulses once, the cycle after the final M; o_Locked=1; o_SymCnt=1 after the trailing S.
- Same config; feed L L M L M → sync still detected via realign (idx goes back to 1 on the second L); o_MatchIdx sequence 1,1,2,3, then o_Sync.
- Pattern LMLM, repeat 3; feed LMLM LMLM S LMLM LMLM LMLM → no sync after the first two matches (rep resets on S); o_Sync on the 5th LMLM.
- LockLen 4 after sync; feed 4 S symbols → o_SymCnt reaches 4, o_Locked drops, state HUNT; a 2nd LMLM then gives a 2nd o_Sync.
- Locked with LockLen 0; assert i_Error together with i_M → o_LockLost pulse, o_Locked=0; a following LMLM resyncs.
- Mid-pattern (idx=2), assert i_Reset for one cycle → all outputs 0 next edge; idx=0; with i_Enable held high, new config is latched and HUNT is entered the edge after reset is released.
